// File: rtl/word_lock_pkg.sv
// word_lock_pkg
//   Shared definitions for the 64b/67b receive word aligner:
//   word widths, framing header codes, the word-lock state
//   enumeration and the 8-bit counter type.
package word_lock_pkg;

    localparam int WORD_W    = 67;
    localparam int PAYLOAD_W = 64;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [1:0] {
        HUNT,
        SLIP,
        WAIT,
        LOCKED
    } state_t;

    typedef logic [7:0] cnt_t;

endpackage

// File: rtl/word_lock_rx_if.sv
// word_lock_rx_if
//   Bundles the gearbox-side input word and the decoded output towards
//   the descrambler, plus the lock status and slip request.
//   Signals:
//     DATA_IN[66:0]   gearbox word ([66] inversion, [65:64] framing)
//     DATA_IN_VALID   DATA_IN qualifier
//     DATA_OUT[63:0]  decoded payload
//     DATA_OUT_CTRL   1 = control word, 0 = data word
//     DATA_OUT_VALID  DATA_OUT/DATA_OUT_CTRL qualifier
//     WORD_LOCK       aligned level
//     SLIP            one-cycle bitslip request
//   master: gearbox/consumer side; slave: the aligner.
interface word_lock_rx_if;
    import word_lock_pkg::*;

    logic [WORD_W-1:0]    DATA_IN;
    logic                 DATA_IN_VALID;
    logic [PAYLOAD_W-1:0] DATA_OUT;
    logic                 DATA_OUT_CTRL;
    logic                 DATA_OUT_VALID;
    logic                 WORD_LOCK;
    logic                 SLIP;

    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        input  DATA_OUT,
        input  DATA_OUT_CTRL,
        input  DATA_OUT_VALID,
        input  WORD_LOCK,
        input  SLIP
    );

    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        output DATA_OUT,
        output DATA_OUT_CTRL,
        output DATA_OUT_VALID,
        output WORD_LOCK,
        output SLIP
    );

endinterface

// File: rtl/word_lock_hdr_chk.sv
// word_lock_hdr_chk
//   Combinational header check and decode of one 67-bit word.
//   Ports:
//     word     in   67-bit gearbox word
//     good     out  framing is 01 or 10
//     ctrl     out  framing bit [65] (1 = control word)
//     payload  out  payload with the inversion bit undone
module word_lock_hdr_chk
    import word_lock_pkg::*;
(
    input  logic [WORD_W-1:0]    word,
    output logic                 good,
    output logic                 ctrl,
    output logic [PAYLOAD_W-1:0] payload
);

    logic [1:0] hdr;

    assign hdr     = word[PAYLOAD_W+1:PAYLOAD_W];
    assign good    = (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
    assign ctrl    = hdr[1];
    assign payload = word[WORD_W-1] ? ~word[PAYLOAD_W-1:0] : word[PAYLOAD_W-1:0];

endmodule

// File: rtl/word_lock_rx.sv
// word_lock_rx
//   64b/67b receive word aligner and decoder. Hunts for LOCK_CNT
//   consecutive good headers, requesting a one-bit slip on each bad
//   header while unaligned; once locked, monitors WIN_CNT-word windows
//   and drops lock after ERR_MAX bad headers in one window.
//   Ports:
//     USER_CLK      in   clock, rising edge
//     SYSTEM_RESET  in   asynchronous active-high reset
//     bus           slave modport of word_lock_rx_if (data in/out,
//                   WORD_LOCK, SLIP); all outputs registered.
module word_lock_rx
    import word_lock_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WIN_CNT   = 64,
    parameter int ERR_MAX   = 16,
    parameter int SLIP_WAIT = 32
) (
    input  logic           USER_CLK,
    input  logic           SYSTEM_RESET,
    word_lock_rx_if.slave  bus
);

    logic                 hdr_good;
    logic                 hdr_ctrl;
    logic [PAYLOAD_W-1:0] hdr_payload;

    state_t state_q, state_d;
    cnt_t   good_cnt_q, good_cnt_d;
    cnt_t   wait_cnt_q, wait_cnt_d;
    cnt_t   win_cnt_q,  win_cnt_d;
    cnt_t   err_cnt_q,  err_cnt_d;
    logic   emit;

    word_lock_hdr_chk u_hdr_chk (
        .word    (bus.DATA_IN),
        .good    (hdr_good),
        .ctrl    (hdr_ctrl),
        .payload (hdr_payload)
    );

    // Counters compare against (limit - 1) before incrementing so that
    // the limit-th qualifying word acts in the same cycle it arrives.
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        wait_cnt_d = wait_cnt_q;
        win_cnt_d  = win_cnt_q;
        err_cnt_d  = err_cnt_q;
        emit       = 1'b0;

        case (state_q)
            HUNT: begin
                if (bus.DATA_IN_VALID) begin
                    if (hdr_good) begin
                        if (good_cnt_q == cnt_t'(LOCK_CNT - 1)) begin
                            // The word completing lock is already emitted.
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                            win_cnt_d  = '0;
                            err_cnt_d  = '0;
                            emit       = 1'b1;
                        end else begin
                            good_cnt_d = good_cnt_q + cnt_t'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                        state_d    = SLIP;
                    end
                end
            end
            SLIP: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
            end
            WAIT: begin
                if (bus.DATA_IN_VALID) begin
                    if (wait_cnt_q == cnt_t'(SLIP_WAIT - 1)) begin
                        state_d    = HUNT;
                        wait_cnt_d = '0;
                        good_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + cnt_t'(1);
                    end
                end
            end
            LOCKED: begin
                if (bus.DATA_IN_VALID) begin
                    emit = hdr_good;
                    // Loss of lock wins over the window boundary.
                    if (!hdr_good && (err_cnt_q == cnt_t'(ERR_MAX - 1))) begin
                        state_d    = SLIP;
                        good_cnt_d = '0;
                        wait_cnt_d = '0;
                        win_cnt_d  = '0;
                        err_cnt_d  = '0;
                    end else if (win_cnt_q == cnt_t'(WIN_CNT - 1)) begin
                        win_cnt_d = '0;
                        err_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + cnt_t'(1);
                        err_cnt_d = err_cnt_q + {7'b0, ~hdr_good};
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            state_q    <= HUNT;
            good_cnt_q <= '0;
            wait_cnt_q <= '0;
            win_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            win_cnt_q  <= win_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // WORD_LOCK and SLIP follow the next state so they line up with the
    // state register; DATA_OUT holds across dropped words.
    always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
        if (SYSTEM_RESET) begin
            bus.DATA_OUT       <= '0;
            bus.DATA_OUT_CTRL  <= 1'b0;
            bus.DATA_OUT_VALID <= 1'b0;
            bus.WORD_LOCK      <= 1'b0;
            bus.SLIP           <= 1'b0;
        end else begin
            bus.DATA_OUT_VALID <= emit;
            bus.WORD_LOCK      <= (state_d == LOCKED);
            bus.SLIP           <= (state_d == SLIP);
            if (emit) begin
                bus.DATA_OUT      <= hdr_payload;
                bus.DATA_OUT_CTRL <= hdr_ctrl;
            end
        end
    end

endmodule
